// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and helpers for the adder datapath
package adder_pkg;

   localparam int ADDER_WIDTH = 64;

   typedef struct packed {
      logic                   carry;
      logic [ADDER_WIDTH-1:0] z;
   } adder_result_t;

   // Number of address bits needed to index 'value' entries (minimum 0).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// rtl/result_fifo_mem.sv - register-array storage for the result FIFO
module result_fifo_mem
   import adder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = ADDER_WIDTH + 1,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Storage needs no reset: the top masks the head whenever it is empty.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_buffer.sv
// rtl/adder_result_buffer.sv - FWFT result buffer with issue credit for the adder
module adder_result_buffer
   import adder_pkg::*;
#(
   parameter int WIDTH        = ADDER_WIDTH,
   parameter int DEPTH        = 4,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      iIssue,
   input  logic                      iResValid,
   input  logic [WIDTH-1:0]          iResZ,
   input  logic                      iResCarry,
   output logic                      oCanIssue,
   output logic                      oValid,
   output logic [WIDTH-1:0]          oZ,
   output logic                      oCarryOut,
   input  logic                      iReadReady,
   output logic [clog2(DEPTH):0]     oCount,
   output logic                      oOverflow,
   output logic                      oUnexpected,
   input  logic                      iClearErr
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = clog2(MAX_INFLIGHT + 1);
   localparam int SW = ((CW > IW) ? CW : IW) + 1;

   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [CW-1:0]  count;
   logic [IW-1:0]  inflight;
   logic [WIDTH:0] rdata;
   logic [SW-1:0]  credit_sum;

   logic full;
   logic pop;
   logic push_ok;
   logic ovf_evt;
   logic unexp_evt;
   logic issue_ok;
   logic ret_ok;

   // A push into a full buffer survives only if the head leaves in the same cycle.
   assign full      = (count == CW'(DEPTH));
   assign pop       = (count != '0) && iReadReady;
   assign push_ok   = iResValid && (!full || pop);
   assign ovf_evt   = iResValid && full && !pop;

   // A result with nothing outstanding is flagged; an issue in the same cycle covers it.
   assign unexp_evt = iResValid && (inflight == '0) && !iIssue;
   assign issue_ok  = iIssue && (inflight != IW'(MAX_INFLIGHT));
   assign ret_ok    = iResValid && !unexp_evt;

   result_fifo_mem #(
      .DEPTH (DEPTH),
      .DW    (WIDTH + 1),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wptr),
      .wdata ({iResCarry, iResZ}),
      .raddr (rptr),
      .rdata (rdata)
   );

   // FIFO pointers and occupancy counter; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Outstanding adder operations: issues that will come back as results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= '0;
      end else begin
         case ({issue_ok, ret_ok})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oOverflow   <= 1'b0;
         oUnexpected <= 1'b0;
      end else begin
         if (ovf_evt) begin
            oOverflow <= 1'b1;
         end else if (iClearErr) begin
            oOverflow <= 1'b0;
         end
         if (unexp_evt) begin
            oUnexpected <= 1'b1;
         end else if (iClearErr) begin
            oUnexpected <= 1'b0;
         end
      end
   end

   // Credit counts stored plus outstanding results so every issued result has a slot.
   assign credit_sum = SW'(count) + SW'(inflight);
   assign oCanIssue  = (credit_sum < SW'(DEPTH)) && (inflight < IW'(MAX_INFLIGHT));

   assign oValid    = (count != '0);
   assign oZ        = oValid ? rdata[WIDTH-1:0] : '0;
   assign oCarryOut = oValid & rdata[WIDTH];
   assign oCount    = count;

endmodule

// File: tb/tb_adder_result_buffer.sv
// tb/tb_adder_result_buffer.sv - self-checking bench for adder_result_buffer
module tb_adder_result_buffer;
   import adder_pkg::*;

   localparam int DEPTH = 4;
   localparam int MAXI  = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iIssue = 1'b0;
   logic        iResValid = 1'b0;
   logic [63:0] iResZ = '0;
   logic        iResCarry = 1'b0;
   logic        iReadReady = 1'b0;
   logic        iClearErr = 1'b0;
   logic        oCanIssue;
   logic        oValid;
   logic [63:0] oZ;
   logic        oCarryOut;
   logic [2:0]  oCount;
   logic        oOverflow;
   logic        oUnexpected;

   adder_result_buffer #(.WIDTH(64), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
      .clk         (clk),
      .reset       (reset),
      .iIssue      (iIssue),
      .iResValid   (iResValid),
      .iResZ       (iResZ),
      .iResCarry   (iResCarry),
      .oCanIssue   (oCanIssue),
      .oValid      (oValid),
      .oZ          (oZ),
      .oCarryOut   (oCarryOut),
      .iReadReady  (iReadReady),
      .oCount      (oCount),
      .oOverflow   (oOverflow),
      .oUnexpected (oUnexpected),
      .iClearErr   (iClearErr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of results, an outstanding-op count and two flags.
   logic [64:0] mq[$];
   int          m_inf = 0;
   bit          m_ovf = 1'b0;
   bit          m_unx = 1'b0;

   typedef struct {
      logic        issue;
      logic        rv;
      logic [63:0] z;
      logic        carry;
      logic        rr;
      logic        clr;
      logic        e_valid;
      logic [63:0] e_z;
      logic        e_carry;
      logic [2:0]  e_count;
      logic        e_can;
      logic        e_ovf;
      logic        e_unx;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int issue, input int rv, input logic [63:0] z, input int carry,
                               input int rr, input int clr, input int e_valid, input logic [63:0] e_z,
                               input int e_carry, input int e_count, input int e_can, input int e_ovf,
                               input int e_unx);
      vec_t v;
      v.issue   = (issue != 0);
      v.rv      = (rv != 0);
      v.z       = z;
      v.carry   = (carry != 0);
      v.rr      = (rr != 0);
      v.clr     = (clr != 0);
      v.e_valid = (e_valid != 0);
      v.e_z     = e_z;
      v.e_carry = (e_carry != 0);
      v.e_count = 3'(e_count);
      v.e_can   = (e_can != 0);
      v.e_ovf   = (e_ovf != 0);
      v.e_unx   = (e_unx != 0);
      return v;
   endfunction

   task automatic drive(input logic issue, input logic rv, input logic [63:0] z, input logic carry,
                        input logic rr, input logic clr);
      iIssue     = issue;
      iResValid  = rv;
      iResZ      = z;
      iResCarry  = carry;
      iReadReady = rr;
      iClearErr  = clr;
   endtask

   task automatic model_reset();
      mq.delete();
      m_inf = 0;
      m_ovf = 1'b0;
      m_unx = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit pop;
      bit ovf_evt;
      bit unx_evt;
      bit eff_issue;
      bit ret;
      pop = (mq.size() > 0) && iReadReady;
      ovf_evt = 1'b0;
      if (pop) void'(mq.pop_front());
      if (iResValid) begin
         if (mq.size() < DEPTH) mq.push_back({iResCarry, iResZ});
         else ovf_evt = 1'b1;
      end
      unx_evt   = iResValid && (m_inf == 0) && !iIssue;
      eff_issue = iIssue && (m_inf < MAXI);
      ret       = iResValid && !unx_evt;
      m_inf     = m_inf + int'(eff_issue) - int'(ret);
      if (ovf_evt) m_ovf = 1'b1;
      else if (iClearErr) m_ovf = 1'b0;
      if (unx_evt) m_unx = 1'b1;
      else if (iClearErr) m_unx = 1'b0;
   endtask

   function automatic bit m_can();
      return ((mq.size() + m_inf) < DEPTH) && (m_inf < MAXI);
   endfunction

   task automatic check_model(input string tag);
      logic [64:0] head;
      head = (mq.size() > 0) ? mq[0] : 65'd0;
      chk({tag, " valid"}, 65'(oValid), 65'(mq.size() != 0));
      chk({tag, " z"}, 65'(oZ), 65'(head[63:0]));
      chk({tag, " carry"}, 65'(oCarryOut), 65'(head[64]));
      chk({tag, " count"}, 65'(oCount), 65'(mq.size()));
      chk({tag, " can_issue"}, 65'(oCanIssue), 65'(m_can()));
      chk({tag, " overflow"}, 65'(oOverflow), 65'(m_ovf));
      chk({tag, " unexpected"}, 65'(oUnexpected), 65'(m_unx));
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
   endtask

   logic [64:0] sum_a;
   logic [64:0] sum_b;
   logic [64:0] sum_c;
   int          issued;

   initial begin
      sum_a = 65'(64'h0000_0000_FFFF_FFF1) + 65'(64'h0000_0000_FF00_110C);
      sum_b = 65'(64'h0000_0000_0000_00FF) + 65'(64'h0000_0000_0000_00FF);
      sum_c = 65'(64'hFFFF_FFFF_FFFF_FFFF) + 65'(64'h0000_0000_0000_0001);

      vecs[0] = mk(1, 0, 64'd0, 0, 0, 0,  0, 64'd0, 0, 0, 1, 0, 0);
      vecs[1] = mk(1, 0, 64'd0, 0, 0, 0,  0, 64'd0, 0, 0, 1, 0, 0);
      vecs[2] = mk(0, 1, sum_a[63:0], int'(sum_a[64]), 1, 0,
                   1, 64'h0000_0001_FF00_10FD, 0, 1, 1, 0, 0);
      vecs[3] = mk(0, 1, sum_b[63:0], int'(sum_b[64]), 1, 0,
                   1, 64'h0000_0000_0000_01FE, 0, 1, 1, 0, 0);
      vecs[4] = mk(0, 0, 64'd0, 0, 1, 0,  0, 64'd0, 0, 0, 1, 0, 0);
      vecs[5] = mk(1, 0, 64'd0, 0, 0, 0,  0, 64'd0, 0, 0, 1, 0, 0);
      vecs[6] = mk(0, 1, sum_c[63:0], int'(sum_c[64]), 0, 0,
                   1, 64'd0, 1, 1, 1, 0, 0);
      vecs[7] = mk(0, 0, 64'd0, 0, 1, 0,  0, 64'd0, 0, 0, 1, 0, 0);
      vecs[8] = mk(0, 1, 64'h1234, 0, 0, 0, 1, 64'h1234, 0, 1, 1, 0, 1);
      vecs[9] = mk(0, 0, 64'd0, 0, 1, 1,  0, 64'd0, 0, 0, 1, 0, 0);

      // Reset state
      @(posedge clk);
      #1;
      chk("rst valid", 65'(oValid), 65'd0);
      chk("rst z", 65'(oZ), 65'd0);
      chk("rst carry", 65'(oCarryOut), 65'd0);
      chk("rst count", 65'(oCount), 65'd0);
      chk("rst can_issue", 65'(oCanIssue), 65'd1);
      chk("rst overflow", 65'(oOverflow), 65'd0);
      chk("rst unexpected", 65'(oUnexpected), 65'd0);
      reset = 1'b0;
      model_reset();

      // Table-driven basic flow, carry and unexpected-result vectors
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].issue, vecs[i].rv, vecs[i].z, vecs[i].carry, vecs[i].rr, vecs[i].clr);
         model_step();
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d valid", i), 65'(oValid), 65'(vecs[i].e_valid));
         chk($sformatf("vec%0d z", i), 65'(oZ), 65'(vecs[i].e_z));
         chk($sformatf("vec%0d carry", i), 65'(oCarryOut), 65'(vecs[i].e_carry));
         chk($sformatf("vec%0d count", i), 65'(oCount), 65'(vecs[i].e_count));
         chk($sformatf("vec%0d can_issue", i), 65'(oCanIssue), 65'(vecs[i].e_can));
         chk($sformatf("vec%0d overflow", i), 65'(oOverflow), 65'(vecs[i].e_ovf));
         chk($sformatf("vec%0d unexpected", i), 65'(oUnexpected), 65'(vecs[i].e_unx));
      end

      // Credit: issue while allowed with no consumer
      issued = 0;
      for (int i = 0; i < 10; i++) begin
         idle();
         if (oCanIssue) begin
            iIssue = 1'b1;
            issued++;
         end
         step("credit_issue");
      end
      chk("credit issues accepted", 65'(issued), 65'd4);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0);
         step("credit_return");
      end
      chk("credit full count", 65'(oCount), 65'd4);
      chk("credit full can_issue", 65'(oCanIssue), 65'd0);
      chk("credit full overflow", 65'(oOverflow), 65'd0);

      // Overflow on a full buffer, clear, then clear racing a new overflow
      drive(1'b0, 1'b1, 64'hDEAD_0000_0000_0001, 1'b0, 1'b0, 1'b0);
      step("ovf_drop");
      chk("ovf set", 65'(oOverflow), 65'd1);
      chk("ovf count held", 65'(oCount), 65'd4);
      drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
      step("ovf_clear");
      chk("ovf cleared", 65'(oOverflow), 65'd0);
      drive(1'b0, 1'b1, 64'hDEAD_0000_0000_0002, 1'b0, 1'b0, 1'b1);
      step("ovf_clear_race");
      chk("ovf set wins", 65'(oOverflow), 65'd1);

      // Full buffer: push and pop together keeps the new result
      drive(1'b0, 1'b1, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b1, 1'b0);
      step("full_push_pop");
      chk("full push_pop count", 65'(oCount), 65'd4);
      drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
      step("single_pop");
      chk("pop restores credit", 65'(oCanIssue), 65'd1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
         step("drain");
      end

      // Stream 10 results through the FIFO with alternating consumer
      for (int i = 0; i < 13; i++) begin
         drive(1'(i % 4 != 3), 1'(i % 4 != 3), {$urandom, $urandom}, 1'($urandom), 1'(i % 2), 1'b0);
         step("wrap");
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
         step("wrap_drain");
      end
      chk("wrap no overflow", 65'(oOverflow), 65'd0);

      // Asynchronous reset with 3 stored and 2 in flight
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
         step("mid_issue");
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0);
         step("mid_result");
      end
      chk("mid pre-reset count", 65'(oCount), 65'd3);
      idle();
      #2;
      reset = 1'b1;
      #1;
      chk("async rst valid", 65'(oValid), 65'd0);
      chk("async rst count", 65'(oCount), 65'd0);
      chk("async rst can_issue", 65'(oCanIssue), 65'd1);
      chk("async rst overflow", 65'(oOverflow), 65'd0);
      chk("async rst unexpected", 65'(oUnexpected), 65'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(1'((m_can() && ($urandom % 2 == 0)) || ($urandom % 20 == 0)),
               1'(((m_inf > 0) && ($urandom % 2 == 0)) || ($urandom % 25 == 0)),
               {$urandom, $urandom}, 1'($urandom),
               1'($urandom % 3 != 0), 1'($urandom % 10 == 0));
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adder_result_buffer.md
Name: adder_result_buffer

Overview:
- Downstream stage of the 64-bit Brent-Kung adder.
- Captures every result the adder produces (sum plus carry-out on the adder's ready pulse) into a small first-word-fall-through FIFO and presents it to the consumer with a valid/ready handshake.
- The adder cannot be stalled, so the block tracks in-flight operations and gives the issuer a credit signal (oCanIssue) that guarantees buffer space.
- Results arriving at a full buffer are dropped and flagged.

Parameters:
- WIDTH, 64, sum width; matches adder iX/iY/oZ.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- MAX_INFLIGHT, 8, maximum outstanding adder operations; sizes the in-flight counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high.
- iIssue  input  1  pulse, tied to the adder iValid: one operation issued this cycle.
- iResValid  input  1  adder oReady: result valid this cycle.
- iResZ  input  WIDTH  adder oZ.
- iResCarry  input  1  adder oCarryOut.
- oCanIssue  output  1  high when the issuer may assert iIssue this cycle.
- oValid  output  1  head entry is valid.
- oZ  output  WIDTH  head sum.
- oCarryOut  output  1  head carry.
- iReadReady  input  1  consumer accepts the head.
- oCount  output  log2(DEPTH)+1  stored entries.
- oOverflow  output  1  sticky; a result was dropped.
- oUnexpected  output  1  sticky; a result arrived with zero in-flight.
- iClearErr  input  1  clears both sticky flags.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: all pointers, oCount and the in-flight counter are 0. oValid, oOverflow and oUnexpected are 0. oZ and oCarryOut are 0. oCanIssue is 1.
- Reset asserted mid-operation discards all stored and in-flight state immediately, with no end-of-cycle wait.
- Storage: DEPTH entries of {carry, sum}, each WIDTH+1 bits. Write and read pointers wrap modulo DEPTH. Occupancy is held in a counter, not derived from pointer compare.
- push = iResValid, accepted if count<DEPTH or a pop occurs in the same cycle.
- pop = oValid && iReadReady.
- Head outputs:
  - oValid = (count != 0).
  - oZ/oCarryOut are driven from the storage entry at the read pointer.
  - When empty, oZ/oCarryOut hold 0 (masked).
- Latency: a result written in cycle N is visible on oValid/oZ in cycle N+1. There is no same-cycle bypass, even when empty.
- Simultaneous push and pop:
  - Non-full: count unchanged, both pointers advance.
  - Full: the push is accepted and nothing is dropped.
- Full with push and no pop: the result is discarded, count and pointers are unchanged, oOverflow is set next cycle.
- Pop with oValid=0: ignored.
- In-flight counter, range 0..MAX_INFLIGHT:
  - +1 on iIssue, -1 on iResValid; both in one cycle leaves it unchanged.
  - iResValid with in-flight==0 (and no iIssue that cycle): oUnexpected is set and the counter stays at 0. The result is still buffered if space allows.
  - Saturates at MAX_INFLIGHT. Issuing at saturation is an issuer protocol violation and is not counted.
- Credit: oCanIssue = (count + inflight) < DEPTH && inflight < MAX_INFLIGHT. It is combinational from registered state only; it has no combinational path from iIssue or iReadReady.
- Sticky flags: iClearErr clears them next cycle. If a set event and iClearErr occur in the same cycle, set wins.

Decomposition:
- Package adder_pkg:
  - ADDER_WIDTH=64.
  - Typedef adder_result_t {logic carry; logic [63:0] z}.
  - Function clog2 for pointer widths.
- One sub-module, result_fifo_mem: DEPTH×(WIDTH+1) register array with write port (we, waddr, wdata) and async read port (raddr, rdata).
- Control, counters and flags stay in the top module.

Test Plan:
- Reset: assert reset mid-stream with 3 entries stored and 2 in flight → same cycle: oValid=0, oCount=0, oCanIssue=1, flags=0.
- Basic flow: issue 0xFFFF_FFF1+0xFF00_110C, then 0xFF+0xFF, with iReadReady=1 → two outputs in order, one cycle after each iResValid: oZ=0x0000_0001_FF00_10FD carry 0, then 0x1FE carry 0.
- Carry: result 0xFFFF_FFFF_FFFF_FFFF+1 → oZ=0, oCarryOut=1.
- Credit: iReadReady=0, issue until oCanIssue drops → exactly 4 issues accepted. After all results return: oCount=4, oCanIssue=0, oOverflow=0. One pop → oCanIssue=1 next cycle.
- Overflow and simultaneous events:
  - Full buffer, force iResValid with no pop → entry dropped, oOverflow=1, oCount=4.
  - Full buffer, push and pop in the same cycle → new result kept at tail, head advances.
  - iClearErr together with a new overflow → oOverflow stays 1.
- Wrap and unexpected:
  - Stream 10 results through DEPTH=4 with alternating iReadReady → data order preserved across pointer wrap.
  - iResValid with zero in-flight → oUnexpected=1 and the result is still stored.
